mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width of the request port.
REQ-002 Parameter LATENCY, default 2, wait cycles between request acceptance and response; legal range 0..15.
REQ-003 clk  input  1  rising-edge clock; the block has one clock.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_w_en  input  4  byte write enables; 4'b0000 means read, any other value means write.
REQ-008 req_addr  input  ADDR_W  byte address.
REQ-009 req_wdata  input  32  write data, with byte i on bits [8i+7:8i].
REQ-010 resp_valid  output  1  response present.
REQ-011 resp_ready  input  1  initiator accepts the response.
REQ-012 resp_rdata  output  32  read data, or 0 for writes and errors.
REQ-013 resp_err  output  1  request was misaligned (req_addr[1:0] != 0).

Function
REQ-014 Storage SHALL be 2^(ADDR_W-2) words of 32 bits, indexed by addr[ADDR_W-1:2].
REQ-015 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE, and SHALL NOT depend combinationally on req_valid.
REQ-017 A request SHALL be accepted at a rising edge where req_valid && req_ready; the block SHALL latch addr, w_en and wdata at that edge.
REQ-018 On acceptance with LATENCY>0, the FSM SHALL go to BUSY with the counter set to LATENCY.
- In BUSY the counter SHALL decrement each cycle.
- At the edge where the counter equals 1, the FSM SHALL commit and enter RESP.
REQ-019 With LATENCY=0, the commit SHALL occur at the acceptance edge and the FSM SHALL go directly to RESP.
REQ-020 resp_valid SHALL be 1 exactly in RESP; the first resp_valid cycle is LATENCY+1 cycles after the acceptance cycle.
REQ-021 Commit for an aligned write SHALL update only the bytes whose w_en bit is set; resp_rdata SHALL be 0 and resp_err 0.
REQ-022 Commit for an aligned read SHALL register the addressed word into resp_rdata; resp_err SHALL be 0.
REQ-023 Commit for a misaligned request SHALL leave memory unmodified, with resp_err=1 and resp_rdata=0.
REQ-024 resp_rdata and resp_err SHALL remain stable while resp_valid=1 && resp_ready=0.
REQ-025 RESP SHALL go to IDLE at the edge where resp_ready=1; resp_valid SHALL be 0 in the following cycle.
REQ-026 Requests SHALL NOT overlap: no new acceptance is possible before the response handshake completes, and back-to-back throughput is one request per LATENCY+2 cycles.
REQ-027 A read of a word written by the previous request SHALL return the updated value.
REQ-028 req_valid changes while req_ready=0 SHALL have no effect.

Reset
REQ-029 When rst=1 at a rising edge, the block SHALL enter IDLE with counter=0, resp_valid=0, resp_rdata=0 and resp_err=0; req_ready SHALL be 1 in the following cycle.
REQ-030 Reset SHALL NOT clear the memory array.
REQ-031 Reset in BUSY SHALL abort the request, and a pending write SHALL NOT be committed.
- Reset in RESP SHALL drop the response without waiting for resp_ready.
REQ-032 rst SHALL have priority over acceptance and commit at the same edge.

Verification
REQ-033 LATENCY=2: write w_en=1111, addr 0x0010, wdata 0xDEADBEEF -> resp_valid first high 3 cycles after acceptance, resp_rdata=0, resp_err=0; then read 0x0010 -> resp_rdata=0xDEADBEEF.
REQ-034 Byte write w_en=0010, wdata 0x0000AB00 to 0x0010 after REQ-033, then read -> 0xDEADABEF.
REQ-035 Read addr 0x0013 -> resp_err=1, resp_rdata=0; a subsequent read of 0x0010 shows memory unchanged.
REQ-036 Hold resp_ready=0 for 5 cycles -> resp_valid and data stable for all 5 cycles and req_ready=0; raising resp_ready -> req_ready=1 the next cycle.
REQ-037 Write 0x12345678 to 0x0020, assert rst in the first BUSY cycle, then read 0x0020 -> the prior contents are returned, not 0x12345678.
REQ-038 LATENCY=0: read accepted in cycle k -> resp_valid=1 in cycle k+1; with resp_ready held 1, the next acceptance happens in cycle k+2.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and the word memory responder (slave).
interface mem_responder_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_w_en;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_w_en, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_w_en, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits LATENCY
// cycles, commits the read/write to a word array, then holds the response
// until the initiator takes it.
module mem_responder #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int WORDS = 1 << (ADDR_W - 2);

  logic [31:0]       mem_q [WORDS];
  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wen_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept;
  logic              commit;
  logic [ADDR_W-1:0] cmtAddr;
  logic [3:0]        cmtWen;
  logic [31:0]       cmtWdata;
  logic [ADDR_W-3:0] cmtIdx;
  logic              cmtMis;
  logic              cmtWrite;

  // With zero latency the commit happens at the acceptance edge, so it must
  // use the live bus fields instead of the latched copies.
  always_comb begin
    accept   = (state_q == IDLE) && bus.req_valid;
    if (LATENCY == 0) begin
      commit   = accept;
      cmtAddr  = bus.req_addr;
      cmtWen   = bus.req_w_en;
      cmtWdata = bus.req_wdata;
    end else begin
      commit   = (state_q == BUSY) && (cnt_q == 4'd1);
      cmtAddr  = addr_q;
      cmtWen   = wen_q;
      cmtWdata = wdata_q;
    end
    cmtIdx   = cmtAddr[ADDR_W-1:2];
    cmtMis   = (cmtAddr[1:0] != 2'b00);
    cmtWrite = (cmtWen != 4'b0000);
  end

  // Next-state and wait-counter logic for the IDLE -> BUSY -> RESP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, request latch and registered response; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wen_q   <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wen_q   <= bus.req_w_en;
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        err_q   <= cmtMis;
        rdata_q <= (!cmtMis && !cmtWrite) ? mem_q[cmtIdx] : 32'd0;
      end
    end
  end

  // Byte-masked write into the array; the array itself is never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && commit && !cmtMis) begin
      for (int b = 0; b < 4; b++) begin
        if (cmtWen[b]) begin
          mem_q[cmtIdx][8*b +: 8] <= cmtWdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one LATENCY=2 instance and one LATENCY=0 instance,
// selected by 'sel', checked against an associative-array memory model.
module tb_mem_responder;

  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;

  logic        sel;
  logic        reqValid;
  logic        respReady;
  logic [3:0]  reqWen;
  logic [15:0] reqAddr;
  logic [31:0] reqWdata;

  logic        obsReqReady;
  logic        obsRespValid;
  logic [31:0] obsRdata;
  logic        obsErr;

  logic [31:0] refMem [int];

  mem_responder_if #(.ADDR_W(ADDR_W)) busA ();
  mem_responder_if #(.ADDR_W(ADDR_W)) busB ();

  assign busA.req_valid  = reqValid && !sel;
  assign busA.resp_ready = respReady && !sel;
  assign busA.req_w_en   = reqWen;
  assign busA.req_addr   = reqAddr;
  assign busA.req_wdata  = reqWdata;
  assign busB.req_valid  = reqValid && sel;
  assign busB.resp_ready = respReady && sel;
  assign busB.req_w_en   = reqWen;
  assign busB.req_addr   = reqAddr;
  assign busB.req_wdata  = reqWdata;

  assign obsReqReady  = sel ? busB.req_ready  : busA.req_ready;
  assign obsRespValid = sel ? busB.resp_valid : busA.resp_valid;
  assign obsRdata     = sel ? busB.resp_rdata : busA.resp_rdata;
  assign obsErr       = sel ? busB.resp_err   : busA.resp_err;

  mem_responder #(.ADDR_W(ADDR_W), .LATENCY(2)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA.slave)
  );

  mem_responder #(.ADDR_W(ADDR_W), .LATENCY(0)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB.slave)
  );

  // Free-running clock and cycle counter used for throughput measurement.
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: misaligned -> error, no memory change; write -> masked
  // byte update, zero data; read -> stored word.
  task automatic modelRequest(input logic [3:0] wen, input logic [15:0] addr,
                              input logic [31:0] wdata,
                              output logic [31:0] expData, output logic expErr);
    int key;
    logic [31:0] v;
    key     = (sel ? 65536 : 0) + int'(addr[15:2]);
    expErr  = (addr[1:0] != 2'b00);
    expData = 32'd0;
    v       = refMem.exists(key) ? refMem[key] : 32'd0;
    if (!expErr) begin
      if (wen == 4'b0000) begin
        expData = v;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (wen[b]) v[8*b +: 8] = wdata[8*b +: 8];
        end
        refMem[key] = v;
      end
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: wait for ready, present request, measure latency,
  // optionally stall the response, then complete the handshake.
  task automatic applyStimulus(input logic [3:0] wen, input logic [15:0] addr,
                               input logic [31:0] wdata, input int holdCycles,
                               input bit noise, output int acceptCycle);
    int n;
    int expLat;
    logic [31:0] expData;
    logic expErr;
    n = 0;
    while (!obsReqReady && n < 50) begin
      stepClk();
      n++;
    end
    checkOutput("req_ready_idle", 32'(obsReqReady), 32'd1);
    reqValid = 1'b1;
    reqWen   = wen;
    reqAddr  = addr;
    reqWdata = wdata;
    @(posedge clk);
    #1;
    acceptCycle = cycle;
    reqValid = 1'b0;
    modelRequest(wen, addr, wdata, expData, expErr);
    expLat = sel ? 1 : 3;
    n = 1;
    while (!obsRespValid && n < 40) begin
      if (noise) begin
        reqValid = 1'($urandom_range(0, 1));
        reqWen   = 4'($urandom);
        reqAddr  = 16'($urandom);
        reqWdata = $urandom;
      end
      stepClk();
      n++;
    end
    reqValid = 1'b0;
    checkOutput("latency", 32'(n), 32'(expLat));
    checkOutput("rdata", obsRdata, expData);
    checkOutput("err", 32'(obsErr), 32'(expErr));
    for (int i = 0; i < holdCycles; i++) begin
      respReady = 1'b0;
      if (noise) begin
        reqValid = 1'($urandom_range(0, 1));
        reqAddr  = 16'($urandom);
      end
      stepClk();
      reqValid = 1'b0;
      checkOutput("hold_valid", 32'(obsRespValid), 32'd1);
      checkOutput("hold_rdata", obsRdata, expData);
      checkOutput("hold_err", 32'(obsErr), 32'(expErr));
      checkOutput("hold_req_ready", 32'(obsReqReady), 32'd0);
    end
    respReady = 1'b1;
    stepClk();
    respReady = 1'b0;
    checkOutput("post_valid", 32'(obsRespValid), 32'd0);
    checkOutput("post_req_ready", 32'(obsReqReady), 32'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, 32'(obsReqReady), 32'd1);
    checkOutput({tag, "_valid"}, 32'(obsRespValid), 32'd0);
    checkOutput({tag, "_rdata"}, obsRdata, 32'd0);
    checkOutput({tag, "_err"}, 32'(obsErr), 32'd0);
  endtask

  // Directed steps followed by a randomized burst.
  initial begin
    int acc0;
    int acc1;
    logic [15:0] a;
    logic [3:0]  w;

    sel       = 1'b0;
    rst       = 1'b1;
    reqValid  = 1'b0;
    respReady = 1'b0;
    reqWen    = 4'd0;
    reqAddr   = 16'd0;
    reqWdata  = 32'd0;
    stepClk();
    stepClk();
    rst = 1'b0;
    checkResetState("rstA");
    sel = 1'b1;
    #1;
    checkResetState("rstB");
    sel = 1'b0;
    #1;

    // Full write then read-back, byte write, misaligned read.
    applyStimulus(4'hF, 16'h0010, 32'hDEADBEEF, 0, 1'b0, acc0);
    applyStimulus(4'h0, 16'h0010, 32'h0, 0, 1'b0, acc0);
    applyStimulus(4'b0010, 16'h0010, 32'h0000AB00, 0, 1'b0, acc0);
    applyStimulus(4'h0, 16'h0010, 32'h0, 0, 1'b0, acc0);
    checkOutput("byte_write_value", refMem[16'h0010 >> 2], 32'hDEADABEF);
    applyStimulus(4'h0, 16'h0013, 32'h0, 0, 1'b0, acc0);
    applyStimulus(4'h0, 16'h0010, 32'h0, 5, 1'b0, acc0);

    // Back-to-back throughput with LATENCY=2.
    applyStimulus(4'h0, 16'h0010, 32'h0, 0, 1'b0, acc0);
    applyStimulus(4'h0, 16'h0010, 32'h0, 0, 1'b0, acc1);
    checkOutput("thru_l2", 32'(acc1 - acc0), 32'd4);

    // Reset during the first BUSY cycle must drop the pending write.
    applyStimulus(4'hF, 16'h0020, 32'hCAFEF00D, 0, 1'b0, acc0);
    reqValid = 1'b1;
    reqWen   = 4'hF;
    reqAddr  = 16'h0020;
    reqWdata = 32'h12345678;
    stepClk();
    reqValid = 1'b0;
    checkOutput("busy_not_ready", 32'(obsReqReady), 32'd0);
    rst = 1'b1;
    stepClk();
    rst = 1'b0;
    checkResetState("rstBusy");
    applyStimulus(4'h0, 16'h0020, 32'h0, 0, 1'b0, acc0);

    // Reset while a response is pending drops it immediately.
    reqValid = 1'b1;
    reqWen   = 4'h0;
    reqAddr  = 16'h0021;
    stepClk();
    reqValid = 1'b0;
    stepClk();
    stepClk();
    checkOutput("resp_before_rst", 32'(obsRespValid), 32'd1);
    checkOutput("resp_err_before_rst", 32'(obsErr), 32'd1);
    rst = 1'b1;
    stepClk();
    rst = 1'b0;
    checkResetState("rstResp");

    // Reset together with a request: nothing accepted.
    reqValid = 1'b1;
    reqWen   = 4'hF;
    reqAddr  = 16'h0020;
    reqWdata = 32'h0BADF00D;
    rst      = 1'b1;
    stepClk();
    rst      = 1'b0;
    reqValid = 1'b0;
    for (int i = 0; i < 4; i++) stepClk();
    checkOutput("rst_vs_accept_valid", 32'(obsRespValid), 32'd0);
    checkOutput("rst_vs_accept_ready", 32'(obsReqReady), 32'd1);
    applyStimulus(4'h0, 16'h0020, 32'h0, 0, 1'b0, acc0);

    // Zero-latency instance: latency, throughput, reset beating commit.
    sel = 1'b1;
    #1;
    applyStimulus(4'hF, 16'h0100, 32'hA5A55A5A, 0, 1'b0, acc0);
    applyStimulus(4'h0, 16'h0100, 32'h0, 0, 1'b0, acc0);
    applyStimulus(4'h0, 16'h0100, 32'h0, 0, 1'b0, acc1);
    checkOutput("thru_l0", 32'(acc1 - acc0), 32'd2);
    reqValid = 1'b1;
    reqWen   = 4'hF;
    reqAddr  = 16'h0100;
    reqWdata = 32'h11112222;
    rst      = 1'b1;
    stepClk();
    rst      = 1'b0;
    reqValid = 1'b0;
    checkResetState("rstB_commit");
    applyStimulus(4'h0, 16'h0100, 32'h0, 2, 1'b0, acc0);

    // Randomized traffic on the LATENCY=2 instance over a small word pool.
    sel = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'hF, 16'(16'h0040 + 4 * i), $urandom, 0, 1'b0, acc0);
    end
    for (int i = 0; i < 30; i++) begin
      a = 16'(16'h0040 + 4 * $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      applyStimulus(w, a, $urandom, $urandom_range(0, 3), 1'b1, acc0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'h0, 16'(16'h0040 + 4 * i), 32'h0, 0, 1'b0, acc0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
